// File: rtl/key_note_seg_scan_if.sv
// Key/display bundle for key_note_seg_scan.
//   Key         : note keys, active high, asynchronous to the design clock
//   codeout     : segment pattern {dp,g,f,e,d,c,b,a}, active high
//   digit_sel   : digit enable, one-hot active-low
//   note_idx    : currently held key index+1, 0 = no key
//   press_pulse : one-cycle strobe per accepted new press
// master = key matrix / display side, slave = key_note_seg_scan.
interface key_note_seg_scan_if #(
   parameter int unsigned NUM_KEYS = 14,
   parameter int unsigned DIGITS   = 4
);
   logic [NUM_KEYS-1:0] Key;
   logic [7:0]          codeout;
   logic [DIGITS-1:0]   digit_sel;
   logic [4:0]          note_idx;
   logic                press_pulse;

   modport master (output Key, input codeout, digit_sel, note_idx, press_pulse);
   modport slave  (input Key, output codeout, digit_sel, note_idx, press_pulse);
endinterface

// File: rtl/key_note_seg_scan.sv
// Note-key to scanned 7-segment history display.
// Synchronises the key vector, priority-encodes it (Key[0] highest), pushes
// the glyph of each new press into a DIGITS-deep history (newest in digit 0)
// and time-multiplexes the history onto a common-cathode digit bank.
// Ports:
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : key_note_seg_scan_if.slave (Key in; codeout, digit_sel,
//            note_idx, press_pulse out, all registered)
// Optional build macro KEY_DEBOUNCE_EN: adds a DB_CYCLES stability filter
// between the synchroniser and the encoder.
module key_note_seg_scan #(
   parameter int unsigned OCTAVES   = 2,
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned DB_CYCLES = 500000
) (
   input logic              clk_in,
   input logic              rst_n,
   key_note_seg_scan_if.slave bus
);
   localparam int unsigned NUM_KEYS = 7 * OCTAVES;
   localparam int unsigned PTR_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DIV_W    = $clog2(SCAN_DIV);

   // Elaboration-time parameter legality check
   if (OCTAVES < 1 || OCTAVES > 2 || DIGITS < 1 || DIGITS > 8 ||
       SCAN_DIV < 2 || DB_CYCLES < 1) begin : g_bad_param
      $error("key_note_seg_scan: illegal parameter value");
   end

   logic [NUM_KEYS-1:0] ks_meta, ks, kd;
   logic [4:0]          cur_c, key_k_c, note_c;
   logic [7:0]          glyph_c;
   logic                press_c;
   logic [4:0]          note_idx_q;
   logic                press_q;
   logic [7:0]          hist [DIGITS];
   logic [DIV_W-1:0]    div_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [DIGITS-1:0]   sel_q;
   logic [7:0]          code_q;

   // Two-flop synchroniser for the asynchronous key vector
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ks_meta <= '0;
         ks      <= '0;
      end else begin
         ks_meta <= bus.Key;
         ks      <= ks_meta;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
   logic [DB_W-1:0]     db_cnt;
   logic [NUM_KEYS-1:0] kd_q;

   // Restart the window on the edge where ks is about to change, so kd
   // follows ks after DB_CYCLES stable cycles; saturate once loaded.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         kd_q   <= '0;
      end else if (ks_meta != ks) begin
         db_cnt <= '0;
      end else begin
         if (db_cnt != DB_W'(DB_CYCLES)) db_cnt <= db_cnt + 1'b1;
         if (db_cnt == DB_W'(DB_CYCLES - 1)) kd_q <= ks;
      end
   end

   assign kd = kd_q;
`else
   assign kd = ks;
`endif

   // Priority encoder: lowest set index wins, result is index+1
   always_comb begin
      cur_c = '0;
      for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
         if (kd[k]) cur_c = 5'(k + 1);
      end
   end

   // Glyph of the winning key: digit (k mod 7)+1, dp for the upper octave
   always_comb begin
      key_k_c = cur_c - 5'd1;
      note_c  = (key_k_c >= 5'd7) ? key_k_c - 5'd7 : key_k_c;
      case (note_c)
         5'd0:    glyph_c = 8'h06;
         5'd1:    glyph_c = 8'h5B;
         5'd2:    glyph_c = 8'h4F;
         5'd3:    glyph_c = 8'h66;
         5'd4:    glyph_c = 8'h6D;
         5'd5:    glyph_c = 8'h7C;
         5'd6:    glyph_c = 8'h07;
         default: glyph_c = 8'h3F;
      endcase
      glyph_c[7] = (key_k_c >= 5'd7);
   end

   assign press_c = (cur_c != 5'd0) && (cur_c != note_idx_q);

   // Press detection and history shift register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         note_idx_q <= '0;
         press_q    <= 1'b0;
         for (int i = 0; i < int'(DIGITS); i++) hist[i] <= 8'h3F;
      end else begin
         note_idx_q <= cur_c;
         press_q    <= press_c;
         if (press_c) begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= glyph_c;
         end
      end
   end

   // Scan divider/pointer; select and segments share the pre-edge pointer
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         ptr_q  <= '0;
         sel_q  <= ~DIGITS'(1);
         code_q <= 8'h3F;
      end else begin
         if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            ptr_q <= (ptr_q == PTR_W'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
         end
         sel_q  <= ~(DIGITS'(1) << ptr_q);
         code_q <= hist[ptr_q];
      end
   end

   assign bus.codeout     = code_q;
   assign bus.digit_sel   = sel_q;
   assign bus.note_idx    = note_idx_q;
   assign bus.press_pulse = press_q;
endmodule

// File: tb/tb_key_note_seg_scan.sv
// Randomised self-checking bench for key_note_seg_scan (DIGITS=4,
// SCAN_DIV=4, DB_CYCLES=8). The reference model works on the raw key
// sample history and plain scan arithmetic.
module tb_key_note_seg_scan;
   localparam int unsigned OCTAVES   = 2;
   localparam int unsigned NUM_KEYS  = 14;
   localparam int unsigned DIGITS    = 4;
   localparam int unsigned SCAN_DIV  = 4;
   localparam int unsigned DB_CYCLES = 8;
`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned DBW = DB_CYCLES;
`else
   localparam int unsigned DBW = 0;
`endif

   logic clk_in = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pcnt  = 0;
   bit   chk_en = 1'b0;

   key_note_seg_scan_if #(.NUM_KEYS(NUM_KEYS), .DIGITS(DIGITS)) kif ();

   key_note_seg_scan #(
      .OCTAVES(OCTAVES), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .bus   (kif.slave)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [13:0] kq [$];          // key samples of the last DBW+2 edges
   logic [13:0] m_kd;
   logic [7:0]  mh [DIGITS];
   int unsigned m_cyc;
   logic [4:0]  m_note;
   logic        m_pulse;
   logic [7:0]  m_code;
   logic [3:0]  m_sel;

   function automatic logic [7:0] glyph(input int k);
      logic [7:0] tab [7] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7C, 8'h07};
      return tab[k % 7] | ((k >= 7) ? 8'h80 : 8'h00);
   endfunction

   function automatic logic [4:0] enc(input logic [13:0] v);
      for (int i = 0; i < 14; i++) if (v[i]) return 5'(i + 1);
      return 5'd0;
   endfunction

   task automatic model_reset();
      kq.delete();
      for (int i = 0; i < int'(DBW) + 2; i++) kq.push_back(14'd0);
      m_kd = '0;
      for (int i = 0; i < int'(DIGITS); i++) mh[i] = 8'h3F;
      m_cyc = 0; m_note = '0; m_pulse = 1'b0; m_code = 8'h3F; m_sel = 4'b1110;
   endtask

   always @(posedge clk_in) begin
      if (rst_n) begin
         automatic bit       same = 1'b1;
         automatic int       ptr;
         automatic logic [4:0] d;
         // A key value is seen once it held for DBW+1 samples, two edges back
         for (int i = 1; i <= int'(DBW); i++) if (kq[i] != kq[0]) same = 1'b0;
         if (same) m_kd = kq[0];
         void'(kq.pop_front());
         kq.push_back(kif.Key);
         ptr    = int'((m_cyc / SCAN_DIV) % DIGITS);
         m_cyc++;
         m_sel  = ~(4'(1) << ptr);
         m_code = mh[ptr];
         d       = enc(m_kd);
         m_pulse = (d != 5'd0) && (d != m_note);
         m_note  = d;
         if (m_pulse) begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) mh[i] = mh[i-1];
            mh[0] = glyph(int'(d) - 1);
         end
      end
   end

   always @(negedge clk_in) begin
      if (rst_n && chk_en) begin
         chk("pulse", 32'(kif.press_pulse), 32'(m_pulse));
         chk("note",  32'(kif.note_idx),    32'(m_note));
         chk("sel",   32'(kif.digit_sel),   32'(m_sel));
         chk("code",  32'(kif.codeout),     32'(m_code));
      end
   end

   always @(posedge clk_in) if (rst_n && kif.press_pulse) pcnt++;

   // ---------------- stimulus ----------------
   task automatic drive(input logic [13:0] v, input int n);
      kif.Key = v;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_code"},  32'(kif.codeout),     32'h3F);
      chk({tag, "_sel"},   32'(kif.digit_sel),   32'hE);
      chk({tag, "_note"},  32'(kif.note_idx),    32'h0);
      chk({tag, "_pulse"}, 32'(kif.press_pulse), 32'h0);
   endtask

   initial begin
      logic [13:0] rv;
      logic [31:0] exp_code;
      rst_n   = 1'b0;
      kif.Key = '0;
      model_reset();
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      #1 chk_reset_vals("reset");
      chk_en = 1'b1;
      @(negedge clk_in);

      // idle scan
      drive(14'h0000, 20);

      // single press of key 1
      pcnt = 0;
      drive(14'h0001, 10 + int'(DBW));
      chk("t2_note", 32'(kif.note_idx), 32'd1);
      drive(14'h0000, 4 + int'(DBW));
      chk("t2_pulses", 32'(pcnt), 32'd1);

      // keys 2, 9, 14 with releases
      drive(14'h0002, 6 + int'(DBW)); drive(14'h0000, 3 + int'(DBW));
      drive(14'h0100, 6 + int'(DBW)); drive(14'h0000, 3 + int'(DBW));
      drive(14'h2000, 6 + int'(DBW)); drive(14'h0000, 3 + int'(DBW));
      for (int i = 0; i < 20; i++) begin
         case (kif.digit_sel)
            4'b1110: exp_code = 32'h87;
            4'b1101: exp_code = 32'hDB;
            4'b1011: exp_code = 32'h5B;
            4'b0111: exp_code = 32'h06;
            default: exp_code = 32'hFFFF;
         endcase
         chk("t3_digit", 32'(kif.codeout), exp_code);
         @(negedge clk_in);
      end

      // lower-priority key added, then higher-priority winner alone
      pcnt = 0;
      drive(14'h0004, 8 + int'(DBW));
      drive(14'h0006, 8 + int'(DBW));
      drive(14'h0002, 8 + int'(DBW));
      chk("t4_note", 32'(kif.note_idx), 32'd2);
      chk("t4_pulses", 32'(pcnt), 32'd2);
      drive(14'h0000, 4 + int'(DBW));

      // short pulse on Key[3], then a long hold
      pcnt = 0;
      drive(14'h0008, 5);
      drive(14'h0000, 6 + int'(DBW));
      chk("glitch_pulses", 32'(pcnt), (5 > DBW) ? 32'd1 : 32'd0);
      pcnt = 0;
      drive(14'h0008, 20);
      chk("hold_pulses", 32'(pcnt), 32'd1);
      drive(14'h0000, 4 + int'(DBW));

      // random key traffic
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 3))
            0:       rv = 14'd0;
            1, 2:    rv = 14'(1) << $urandom_range(0, 13);
            default: rv = 14'($urandom);
         endcase
         drive(rv, int'($urandom_range(1, 6 + DBW)));
      end

      // asynchronous reset mid-scan with a full history
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk_reset_vals("async_rst");
      repeat (2) @(negedge clk_in);
      kif.Key = '0;
      rst_n   = 1'b1;
      @(negedge clk_in);
      drive(14'h0000, 24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
